write_buffer: RTL

- Write-side counterpart of the wide-read element buffer: collects WIDTH-bit elements from the compute pipeline into one FULL_WIDTH line and issues a single wide memory write with a per-element mask.
- Sits between the PageRank update stage and the memory write port.
- Mirrors the read-side layout: element slot 0 is the most significant WIDTH bits of the line.
- Supports a starting slot offset (base) and an early flush for partial lines.

---
 rtl/write_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/write_buffer.sv
// write_buffer
//   Collects WIDTH-bit elements from the compute pipeline into one FULL_WIDTH
//   line and issues a single wide memory write with a per-element mask.
//   Slot 0 is the most significant WIDTH bits of the line. A line can start at
//   a slot offset (base) and a partial line can be issued early with flush.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FILL  | accepting elements into the line, no write pending
//   DRAIN | line complete or flushed, wide write held until wready
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   idata_valid/idata  element offered by the pipeline
//   idata_ready        buffer accepts an element this cycle
//   base               starting slot, sampled on first accept into empty buffer
//   flush              issue the current partial line
//   wvalid/wready      wide write handshake
//   wdata, wmask       line data and element-valid mask (bit MAX_ELEMS-1-k = slot k)
//   elems              number of elements currently held
module write_buffer #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             idata_valid,
    input  logic [WIDTH-1:0]                 idata,
    output logic                             idata_ready,
    input  logic [7:0]                       base,
    input  logic                             flush,
    output logic                             wvalid,
    output logic [FULL_WIDTH-1:0]            wdata,
    output logic [(FULL_WIDTH/WIDTH)-1:0]    wmask,
    input  logic                             wready,
    output logic [7:0]                       elems
);

    localparam int         MAX_ELEMS = FULL_WIDTH / WIDTH;
    localparam logic [7:0] MAX8      = 8'(MAX_ELEMS);
    localparam logic [7:0] LAST8     = 8'(MAX_ELEMS - 1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    state_t     state;
    logic [7:0] wptr;
    logic [7:0] slot;
    logic       accept;
    logic       go_drain;

    always_comb begin
        accept = idata_valid && idata_ready && (state == FILL);
        // base only matters for the first element of a line; out-of-range
        // offsets start the line at slot 0
        if (elems == 8'd0) begin
            slot = (base < MAX8) ? base : 8'd0;
        end else begin
            slot = wptr;
        end
        go_drain = (accept && (slot == LAST8))
                 || (flush && ((elems != 8'd0) || accept));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wvalid      <= 1'b0;
            wmask       <= '0;
            wdata       <= '0;
            elems       <= 8'd0;
            wptr        <= 8'd0;
            idata_ready <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < MAX_ELEMS; k++) begin
                            if (slot == 8'(k)) begin
                                wdata[FULL_WIDTH-1-WIDTH*k -: WIDTH] <= idata;
                                wmask[MAX_ELEMS-1-k]                 <= 1'b1;
                            end
                        end
                        elems <= elems + 8'd1;
                        // the last slot sends us to DRAIN, so wptr stays in range
                        if (slot != LAST8) begin
                            wptr <= slot + 8'd1;
                        end
                    end
                    if (go_drain) begin
                        state       <= DRAIN;
                        wvalid      <= 1'b1;
                        idata_ready <= 1'b0;
                    end else begin
                        idata_ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (wready) begin
                        state       <= FILL;
                        wvalid      <= 1'b0;
                        wmask       <= '0;
                        wdata       <= '0;
                        elems       <= 8'd0;
                        wptr        <= 8'd0;
                        idata_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
